itch_msg_sequencer: RTL and testbench
=====================================

Name: itch_msg_sequencer

Overview:
- Sits between the eth/udp parser output and the order-book update logic.
- Walks the MoldUDP64 payload: session ID, sequence number and message count, then per-message 2-byte length prefix and message body.
- Emits one framed ITCH message stream (first/last strobes) with the current sequence number.
- Tracks the expected sequence number: flags gaps, drops duplicate packets, and aborts cleanly on malformed or truncated payloads.

Parameters:
SESS_CHECK_EN  1       1 = drop packets whose session ID differs from SESS_ID
SESS_ID        80'h0   expected 10-byte session ID, big-endian
MAX_MSG_LEN    50      largest legal message length in bytes; 0 and >MAX_MSG_LEN are errors

Ports:
clk          in   1    system clock
rstN         in   1    asynchronous active-low reset
payValid     in   1    UDP payload byte valid; no backpressure
payData      in   8    UDP payload byte
payStart     in   1    qualifies the first payload byte (with payValid)
payLast      in   1    qualifies the final payload byte (with payValid)
msgValid     out  1    message byte valid
msgData      out  8    message byte; first byte is the ITCH message type
msgFirst     out  1    first byte of a message
msgLast      out  1    final byte of a message
msgAbort     out  1    1-cycle pulse: open message ended early, discard it
curSeqNum    out  64   sequence number of the message on msgData
seqGap       out  1    1-cycle pulse: packet seqNum > expected
gapCnt       out  32   saturating count of missing sequence numbers
dupDrop      out  1    1-cycle pulse: packet dropped (stale seq or session mismatch)
errLen       out  1    1-cycle pulse: illegal message length
errTrunc     out  1    1-cycle pulse: payLast before all messages completed
sessEnd      out  1    sticky: end-of-session (msgCnt 0xFFFF) seen

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; synced=0; expSeq=0; gapCnt=0.
- Latency: every output registered; msgData/msgValid appear 1 clk after the accepted payload byte.
- States: IDLE, SESS(10 B), SEQ(8 B), CNT(2 B), LEN_HI, LEN_LO, BODY, DRAIN. A byte counter steps only on payValid.
- IDLE -> SESS on payValid & payStart. Bytes without payStart in IDLE are ignored.
- SESS: compare against SESS_ID. On mismatch with SESS_CHECK_EN=1, go to DRAIN and pulse dupDrop at the end of SESS.
- SEQ: assemble pktSeq big-endian.
- CNT: assemble msgCnt. Evaluation happens on the 2nd CNT byte:
  - msgCnt=0xFFFF: set sessEnd, go to DRAIN.
  - If synced and pktSeq<expSeq: pulse dupDrop, go to DRAIN.
  - If synced and pktSeq>expSeq: pulse seqGap; gapCnt += pktSeq-expSeq, saturating at 0xFFFFFFFF.
  - Then: set synced=1, expSeq=pktSeq+msgCnt (64-bit wrap), curSeqNum=pktSeq.
  - msgCnt=0 (heartbeat): go to DRAIN.
  - Otherwise go to LEN_HI.
- LEN_HI/LEN_LO: assemble msgLen. If msgLen==0 or msgLen>MAX_MSG_LEN: pulse errLen, go to DRAIN. Else go to BODY.
- BODY: forward each byte. msgFirst on body byte 1; msgLast on byte msgLen (both can coincide when msgLen=1). After msgLast: decrement remaining count, increment curSeqNum; if remaining==0 go to DRAIN, else go to LEN_HI.
- DRAIN: discard bytes until payLast, then go to IDLE.
- payLast in any state except DRAIN/IDLE with messages still outstanding:
  - pulse errTrunc;
  - if in BODY and the byte is not the message's last, also pulse msgAbort (1 clk after, no msgLast);
  - go to IDLE.
- payLast that coincides with a msgLast completing the final message is normal: no errTrunc.
- payStart while not IDLE: restart at SESS with this byte as session byte 0. If a message is open, pulse msgAbort. expSeq is unchanged.
- Gaps in payValid are allowed anywhere; state holds.
- Stale-sequence comparison is unsigned on 64 bits; wrap is not handled.

Test Plan:
- Packet seq=1, msgCnt=1, msgLen=36 add order (type 0x41) -> 36 msgValid bytes, msgFirst with msgData=0x41, msgLast on byte 36, curSeqNum=1, no error pulses.
- Packet seq=1 cnt=2 (lengths 19 'D', 31 'E'), then seq=3 cnt=1 -> three messages with curSeqNum 1,2,3; seqGap never asserted.
- seq=1 cnt=1, then seq=5 cnt=1 -> seqGap pulse, gapCnt=3, message forwarded with curSeqNum=5. Then seq=4 -> dupDrop, no msgValid.
- msgLen=0x0000 and msgLen=51 packets -> errLen pulse, no msgValid, next good packet processed normally.
- payLast on body byte 10 of a 36-byte message -> msgAbort and errTrunc pulses, no msgLast; msgCnt=0xFFFF packet -> sessEnd=1, stays set until rstN low.
- rstN low mid-BODY -> all outputs 0 immediately; first packet after reset with seq=100 -> no seqGap (unsynced).

Source files
------------

// File: rtl/itch_msg_sequencer.sv
// MoldUDP64 payload walker: frames ITCH messages out of a UDP payload byte stream
// and tracks the expected sequence number across packets (gaps, duplicates, truncation).
module itch_msg_sequencer #(
  parameter bit          SESS_CHECK_EN = 1'b1,
  parameter logic [79:0] SESS_ID       = 80'h0,
  parameter int          MAX_MSG_LEN   = 50
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        payValid,
  input  logic [7:0]  payData,
  input  logic        payStart,
  input  logic        payLast,
  output logic        msgValid,
  output logic [7:0]  msgData,
  output logic        msgFirst,
  output logic        msgLast,
  output logic        msgAbort,
  output logic [63:0] curSeqNum,
  output logic        seqGap,
  output logic [31:0] gapCnt,
  output logic        dupDrop,
  output logic        errLen,
  output logic        errTrunc,
  output logic        sessEnd
);
  typedef enum logic [2:0] {IDLE, SESS, SEQ, CNT, LEN_HI, LEN_LO, BODY, DRAIN} state_t;

  state_t      state;
  logic [15:0] byte_cnt;
  logic [79:0] sess_sr;
  logic        sess_ok;
  logic [63:0] pkt_seq, exp_seq, msg_seq;
  logic        synced;
  logic [7:0]  cnt_hi;
  logic [15:0] msg_len, msg_rem;

  // payStart re-enters SESS from any state, so each byte is decoded against its effective state.
  state_t      eff_state;
  logic [15:0] eff_cnt, cnt_word, len_word;
  logic [79:0] sess_cmp;
  logic        sess_match, sess_bad_end, stale, len_bad, body_last, pkt_done, msg_open;
  logic [64:0] gap_sum;
  logic [31:0] gap_next;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    eff_state    = payStart ? SESS : state;
    eff_cnt      = payStart ? 16'd0 : byte_cnt;
    sess_cmp     = payStart ? SESS_ID : sess_sr;
    sess_match   = (payData == sess_cmp[79:72]);
    sess_bad_end = SESS_CHECK_EN && (eff_cnt == 16'd9) && !((payStart || sess_ok) && sess_match);
    stale        = synced && (pkt_seq < exp_seq);
    cnt_word     = {cnt_hi, payData};
    len_word     = {msg_len[15:8], payData};
    len_bad      = (len_word == 16'd0) || (len_word > 16'(MAX_MSG_LEN));
    body_last    = ((eff_cnt + 16'd1) == msg_len);
    msg_open     = (state == BODY) && (byte_cnt != 16'd0);
    gap_sum      = {33'd0, gapCnt} + {1'b0, pkt_seq - exp_seq};
    gap_next     = (gap_sum > 65'h0_FFFF_FFFF) ? 32'hFFFF_FFFF : gap_sum[31:0];
    // pkt_done: this byte finishes the packet's useful content, so a payLast here is legal.
    pkt_done     = 1'b0;
    case (eff_state)
      SESS:    pkt_done = sess_bad_end;
      CNT:     pkt_done = (eff_cnt == 16'd1) &&
                          ((cnt_word == 16'hFFFF) || stale || (cnt_word == 16'd0));
      LEN_LO:  pkt_done = len_bad;
      BODY:    pkt_done = body_last && (msg_rem == 16'd1);
      DRAIN:   pkt_done = 1'b1;
      default: pkt_done = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      sess_sr   <= '0;
      sess_ok   <= 1'b0;
      pkt_seq   <= '0;
      exp_seq   <= '0;
      msg_seq   <= '0;
      synced    <= 1'b0;
      cnt_hi    <= '0;
      msg_len   <= '0;
      msg_rem   <= '0;
      msgValid  <= 1'b0;
      msgData   <= '0;
      msgFirst  <= 1'b0;
      msgLast   <= 1'b0;
      msgAbort  <= 1'b0;
      curSeqNum <= '0;
      seqGap    <= 1'b0;
      gapCnt    <= '0;
      dupDrop   <= 1'b0;
      errLen    <= 1'b0;
      errTrunc  <= 1'b0;
      sessEnd   <= 1'b0;
    end else begin
      // NOTE: non-blocking only; the payLast block below relies on the last assignment winning.
      msgValid <= 1'b0;
      msgFirst <= 1'b0;
      msgLast  <= 1'b0;
      msgAbort <= 1'b0;
      seqGap   <= 1'b0;
      dupDrop  <= 1'b0;
      errLen   <= 1'b0;
      errTrunc <= 1'b0;
      if (payValid) begin
        state    <= eff_state;
        byte_cnt <= eff_cnt + 16'd1;
        if (payStart && msg_open) msgAbort <= 1'b1;
        case (eff_state)
          SESS: begin
            sess_sr <= sess_cmp << 8;
            sess_ok <= (payStart || sess_ok) && sess_match;
            if (eff_cnt == 16'd9) begin
              byte_cnt <= '0;
              if (sess_bad_end) begin
                dupDrop <= 1'b1;
                state   <= DRAIN;
              end else begin
                state <= SEQ;
              end
            end
          end
          SEQ: begin
            pkt_seq <= {pkt_seq[55:0], payData};
            if (eff_cnt == 16'd7) begin
              byte_cnt <= '0;
              state    <= CNT;
            end
          end
          CNT: begin
            cnt_hi <= payData;
            if (eff_cnt == 16'd1) begin
              byte_cnt <= '0;
              if (cnt_word == 16'hFFFF) begin
                sessEnd <= 1'b1;
                state   <= DRAIN;
              end else if (stale) begin
                dupDrop <= 1'b1;
                state   <= DRAIN;
              end else begin
                if (synced && (pkt_seq > exp_seq)) begin
                  seqGap <= 1'b1;
                  gapCnt <= gap_next;
                end
                synced    <= 1'b1;
                exp_seq   <= pkt_seq + {48'd0, cnt_word};
                msg_seq   <= pkt_seq;
                curSeqNum <= pkt_seq;
                msg_rem   <= cnt_word;
                state     <= (cnt_word == 16'd0) ? DRAIN : LEN_HI;
              end
            end
          end
          LEN_HI: begin
            msg_len[15:8] <= payData;
            state         <= LEN_LO;
          end
          LEN_LO: begin
            msg_len  <= len_word;
            byte_cnt <= '0;
            if (len_bad) begin
              errLen <= 1'b1;
              state  <= DRAIN;
            end else begin
              state <= BODY;
            end
          end
          BODY: begin
            msgValid  <= 1'b1;
            msgData   <= payData;
            msgFirst  <= (eff_cnt == 16'd0);
            curSeqNum <= msg_seq;
            if (body_last) begin
              msgLast <= 1'b1;
              msg_rem <= msg_rem - 16'd1;
              msg_seq <= msg_seq + 64'd1;
              state   <= (msg_rem == 16'd1) ? DRAIN : LEN_HI;
            end
          end
          default: ;
        endcase
        if (payLast && (eff_state != IDLE)) begin
          state <= IDLE;
          if (!pkt_done) begin
            errTrunc <= 1'b1;
            if ((eff_state == BODY) && !body_last) msgAbort <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_itch_msg_sequencer.sv
// Bench for itch_msg_sequencer: a packet-level MoldUDP64 model predicts forwarded bytes
// and error pulses; a negedge monitor compares every output byte and tallies pulses.
module tb_itch_msg_sequencer;
  localparam logic [79:0] SID  = 80'h4E41_5344_4151_3030_3031;
  localparam int          MAXL = 50;

  logic        clk = 1'b0, rstN = 1'b1;
  logic        payValid = 1'b0, payStart = 1'b0, payLast = 1'b0;
  logic [7:0]  payData = 8'h00;
  logic        msgValid, msgFirst, msgLast, msgAbort, seqGap, dupDrop, errLen, errTrunc, sessEnd;
  logic [7:0]  msgData;
  logic [63:0] curSeqNum;
  logic [31:0] gapCnt;

  itch_msg_sequencer #(.SESS_CHECK_EN(1'b1), .SESS_ID(SID), .MAX_MSG_LEN(MAXL)) dut (
    .clk(clk), .rstN(rstN), .payValid(payValid), .payData(payData), .payStart(payStart),
    .payLast(payLast), .msgValid(msgValid), .msgData(msgData), .msgFirst(msgFirst),
    .msgLast(msgLast), .msgAbort(msgAbort), .curSeqNum(curSeqNum), .seqGap(seqGap),
    .gapCnt(gapCnt), .dupDrop(dupDrop), .errLen(errLen), .errTrunc(errTrunc), .sessEnd(sessEnd));

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  data;
    bit          first;
    bit          last;
    bit          abort;
    logic [63:0] seq;
  } rec_t;

  rec_t        exp_q[$];
  logic [7:0]  pkt[$];

  bit          m_synced, m_sessend, m_pend_abort;
  logic [63:0] m_exp;
  logic [31:0] m_gapcnt;
  int          m_gap, m_dup, m_len, m_trunc, m_abort_solo;

  int          o_gap, o_dup, o_len, o_trunc, o_abort, o_abort_solo, o_bytes, o_lasts, o_first_data;
  logic [63:0] o_last_seq;

  task automatic clear_all();
    exp_q.delete();
    m_synced = 0; m_sessend = 0; m_pend_abort = 0; m_exp = '0; m_gapcnt = '0;
    m_gap = 0; m_dup = 0; m_len = 0; m_trunc = 0; m_abort_solo = 0;
    o_gap = 0; o_dup = 0; o_len = 0; o_trunc = 0; o_abort = 0; o_abort_solo = 0;
    o_bytes = 0; o_lasts = 0; o_first_data = 0; o_last_seq = '0;
  endtask

  // Monitor: every forwarded byte is matched against the model's queue.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      if (rstN) begin
        if (msgValid) begin
          o_bytes++;
          if (msgFirst) o_first_data = int'(msgData);
          if (msgLast) o_lasts++;
          o_last_seq = curSeqNum;
          check("msg_byte_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            check("msg_fields", {msgData, msgFirst, msgLast, msgAbort},
                  {r.data, r.first, r.last, r.abort});
            check("msg_seq", curSeqNum, r.seq);
          end
        end
        if (msgAbort) o_abort++;
        if (msgAbort && !msgValid) o_abort_solo++;
        o_gap   += int'(seqGap);
        o_dup   += int'(dupDrop);
        o_len   += int'(errLen);
        o_trunc += int'(errTrunc);
      end
    end
  end

  // Packet-level model: walks the whole payload as a byte array.
  task automatic model_pkt(input bit has_last);
    int          n, p;
    logic [79:0] s;
    logic [63:0] seq, cur;
    logic [15:0] cnt, len;
    logic [64:0] sum;
    rec_t        r;
    bit          trunc_here;
    n = pkt.size();
    if (m_pend_abort) begin m_abort_solo++; m_pend_abort = 0; end
    if (n < 10) begin if (has_last) m_trunc++; return; end
    s = '0;
    for (int i = 0; i < 10; i++) s = {s[71:0], pkt[i]};
    if (s != SID) begin m_dup++; return; end
    if (n < 20) begin if (has_last) m_trunc++; return; end
    seq = '0;
    for (int i = 10; i < 18; i++) seq = {seq[55:0], pkt[i]};
    cnt = {pkt[18], pkt[19]};
    if (cnt == 16'hFFFF) begin m_sessend = 1; return; end
    if (m_synced && seq < m_exp) begin m_dup++; return; end
    if (m_synced && seq > m_exp) begin
      m_gap++;
      sum = 65'(m_gapcnt) + 65'(seq - m_exp);
      m_gapcnt = (sum > 65'h0_FFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
    end
    m_synced = 1;
    m_exp    = seq + 64'(cnt);
    cur      = seq;
    p        = 20;
    for (int m = 0; m < int'(cnt); m++) begin
      if (p + 2 > n) begin if (has_last) m_trunc++; return; end
      len = {pkt[p], pkt[p+1]};
      p += 2;
      if (len == 0 || len > MAXL) begin m_len++; return; end
      for (int k = 0; k < int'(len); k++) begin
        if (p >= n) begin
          if (has_last) m_trunc++;
          else if (k > 0) m_pend_abort = 1;
          return;
        end
        trunc_here = has_last && (p == n - 1) && (k != int'(len) - 1);
        r.data = pkt[p]; r.first = (k == 0); r.last = (k == int'(len) - 1);
        r.abort = trunc_here; r.seq = cur;
        exp_q.push_back(r);
        p++;
        if (trunc_here) begin m_trunc++; return; end
      end
      cur++;
      if (p == n && has_last && m != int'(cnt) - 1) begin m_trunc++; return; end
    end
  endtask

  task automatic hdr(input logic [79:0] s, input logic [63:0] seq, input logic [15:0] cnt);
    pkt.delete();
    for (int i = 9; i >= 0; i--) pkt.push_back(s[8*i +: 8]);
    for (int i = 7; i >= 0; i--) pkt.push_back(seq[8*i +: 8]);
    pkt.push_back(cnt[15:8]);
    pkt.push_back(cnt[7:0]);
  endtask

  task automatic add_msg(input int len_field, input int body_len, input logic [7:0] typ);
    pkt.push_back(len_field[15:8]);
    pkt.push_back(len_field[7:0]);
    for (int k = 0; k < body_len; k++) pkt.push_back(k == 0 ? typ : 8'($urandom));
  endtask

  task automatic cut_pkt(input int keep);
    while (pkt.size() > keep) void'(pkt.pop_back());
  endtask

  task automatic drive(input logic [7:0] d, input bit s, input bit l);
    payValid = 1'b1; payData = d; payStart = s; payLast = l;
    @(posedge clk); #1;
    payValid = 1'b0; payStart = 1'b0; payLast = 1'b0;
  endtask

  task automatic run_pkt(input bit has_last, input bit gaps);
    model_pkt(has_last);
    for (int i = 0; i < pkt.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      drive(pkt[i], i == 0, has_last && (i == pkt.size() - 1));
    end
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
    check("seqGap_pulses", o_gap, m_gap);
    check("dupDrop_pulses", o_dup, m_dup);
    check("errLen_pulses", o_len, m_len);
    check("errTrunc_pulses", o_trunc, m_trunc);
    check("restart_abort_pulses", o_abort_solo, m_abort_solo);
    check("gapCnt", gapCnt, m_gapcnt);
    check("sessEnd", sessEnd, m_sessend);
    check("model_queue_drained", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    #1;
    check("reset_outputs",
          {msgValid, msgData, msgFirst, msgLast, msgAbort, curSeqNum, seqGap, gapCnt,
           dupDrop, errLen, errTrunc, sessEnd}, '0);
    clear_all();
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [79:0] s;
    logic [63:0] seq;
    int          cnt, r, bl;
    bit          has_last;

    #2;
    do_reset();

    // Single add-order message.
    hdr(SID, 64'd1, 16'd1); add_msg(36, 36, 8'h41); run_pkt(1, 0); settle();
    check("s1_bytes", o_bytes, 36);
    check("s1_type", o_first_data, 8'h41);
    check("s1_seq", o_last_seq, 64'd1);
    check("s1_errors", o_gap + o_dup + o_len + o_trunc + o_abort, 0);

    // Two messages then a contiguous packet.
    do_reset();
    hdr(SID, 64'd1, 16'd2); add_msg(19, 19, 8'h44); add_msg(31, 31, 8'h45); run_pkt(1, 1); settle();
    hdr(SID, 64'd3, 16'd1); add_msg(10, 10, 8'h41); run_pkt(1, 1); settle();
    check("s2_gap", o_gap, 0);
    check("s2_bytes", o_bytes, 60);
    check("s2_last_seq", o_last_seq, 64'd3);

    // Gap then a stale packet.
    do_reset();
    hdr(SID, 64'd1, 16'd1); add_msg(12, 12, 8'h41); run_pkt(1, 0); settle();
    hdr(SID, 64'd5, 16'd1); add_msg(12, 12, 8'h41); run_pkt(1, 0); settle();
    check("s3_gapCnt", gapCnt, 32'd3);
    check("s3_gap_pulse", o_gap, 1);
    check("s3_seq", o_last_seq, 64'd5);
    hdr(SID, 64'd4, 16'd1); add_msg(12, 12, 8'h41); run_pkt(1, 0); settle();
    check("s3_dup", o_dup, 1);
    check("s3_bytes", o_bytes, 24);

    // Illegal lengths then a good packet.
    do_reset();
    hdr(SID, 64'd1, 16'd1); add_msg(0, 0, 8'h00); run_pkt(1, 0); settle();
    hdr(SID, 64'd2, 16'd1); add_msg(51, 51, 8'h41); run_pkt(1, 0); settle();
    check("s4_errLen", o_len, 2);
    check("s4_no_bytes", o_bytes, 0);
    hdr(SID, 64'd3, 16'd1); add_msg(8, 8, 8'h50); run_pkt(1, 0); settle();
    check("s4_good_bytes", o_bytes, 8);

    // Truncation on body byte 10, then end-of-session.
    do_reset();
    hdr(SID, 64'd1, 16'd1); add_msg(36, 36, 8'h41); cut_pkt(32); run_pkt(1, 0); settle();
    check("s5_abort", o_abort, 1);
    check("s5_trunc", o_trunc, 1);
    check("s5_no_last", o_lasts, 0);
    check("s5_bytes", o_bytes, 10);
    hdr(SID, 64'd2, 16'hFFFF); run_pkt(1, 0); settle();
    check("s5_sessEnd", sessEnd, 1'b1);
    hdr(SID, 64'd2, 16'd1); add_msg(5, 5, 8'h41); run_pkt(1, 0); settle();
    check("s5_sessEnd_sticky", sessEnd, 1'b1);

    // Unterminated packet with an open message, restarted by the next payStart.
    do_reset();
    hdr(SID, 64'd1, 16'd2); add_msg(20, 20, 8'h41); add_msg(20, 20, 8'h42); cut_pkt(49);
    run_pkt(0, 0);
    hdr(SID, 64'd3, 16'd1); add_msg(10, 10, 8'h43); run_pkt(1, 0); settle();
    check("s6_restart_abort", o_abort_solo, 1);
    check("s6_seq", o_last_seq, 64'd3);

    // Randomized packets with gaps, duplicates, bad sessions, bad lengths and cuts.
    for (int t = 0; t < 150; t++) begin
      s = SID;
      if ($urandom_range(0, 11) == 0) s[8*$urandom_range(0, 9) +: 8] ^= 8'h5A;
      if (!m_synced) seq = 64'($urandom_range(1, 1000));
      else begin
        r = $urandom_range(0, 9);
        if (r < 2) seq = m_exp + 64'($urandom_range(1, 5));
        else if (r == 2 && m_exp > 3) seq = m_exp - 64'($urandom_range(1, 3));
        else seq = m_exp;
      end
      cnt = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
      hdr(s, seq, 16'(cnt));
      for (int m = 0; m < cnt; m++) begin
        r = $urandom_range(0, 14);
        if (r == 0) add_msg(0, 0, 8'h00);
        else if (r == 1) add_msg(51 + $urandom_range(0, 9), 5, 8'h41);
        else begin bl = $urandom_range(1, MAXL); add_msg(bl, bl, 8'h41 + 8'(m)); end
      end
      if ($urandom_range(0, 5) == 0)
        for (int k = 0; k < 3; k++) pkt.push_back(8'($urandom));
      has_last = 1;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        cut_pkt($urandom_range(1, pkt.size() - 1));
        has_last = (r == 0);
      end
      run_pkt(has_last, 1);
      settle();
    end

    // Gap counter saturation.
    do_reset();
    hdr(SID, 64'd1, 16'd1); add_msg(4, 4, 8'h41); run_pkt(1, 0); settle();
    hdr(SID, 64'h1_0000_0002, 16'd1); add_msg(4, 4, 8'h41); run_pkt(1, 0); settle();
    check("sat_gapCnt", gapCnt, 32'hFFFF_FFFF);

    // Reset in the middle of a message body; next packet must not flag a gap.
    hdr(SID, 64'h1_0000_0003, 16'd1); add_msg(36, 36, 8'h41); cut_pkt(30); run_pkt(0, 0);
    do_reset();
    hdr(SID, 64'd100, 16'd1); add_msg(5, 5, 8'h41); run_pkt(1, 0); settle();
    check("s7_no_gap", o_gap, 0);
    check("s7_seq", o_last_seq, 64'd100);
    check("s7_bytes", o_bytes, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
